// File: rtl/button_event_pkg.sv
`default_nettype none
// ============================================================================
// Package : button_event_pkg
// Purpose : Types shared by the button gesture decoder and its output stage.
//           Holds the event codes presented on event_code and the gesture
//           FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package button_event_pkg;

  // Classified gesture events. The encoding is visible on event_code.
  typedef enum logic [1:0] {
    EV_SINGLE     = 2'd0,
    EV_DOUBLE     = 2'd1,
    EV_HOLD_START = 2'd2,
    EV_HOLD_END   = 2'd3
  } event_code_e;

  // Gesture classifier states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_HOLD  = 2'd2
  } gesture_state_e;

endpackage : button_event_pkg
`default_nettype wire

// File: rtl/event_holding_reg.sv
`default_nettype none
// ============================================================================
// Module  : event_holding_reg
// Purpose : One-entry output register for classified events with a
//           valid/ready handshake and a sticky overflow flag.
//           A new event is loaded when the register is empty or is being
//           consumed in the same cycle (no bubble); otherwise it is dropped
//           and overflow is set. Everything is frozen while clk_en_i is low.
// Ports   : clk, async_rst_n     - clock, asynchronous active-low reset
//           clk_en_i             - update qualifier
//           emit_i, emit_code_i  - event decided in this cycle
//           event_ready_i        - consumer accepts the held event
//           event_valid_o        - held event present
//           event_code_o         - held event code
//           overflow_o           - sticky: an event was dropped
//           overflow_clr_i       - clears overflow (a same-cycle drop wins)
// Revision: 1.0 - initial release
// ============================================================================
module event_holding_reg
  import button_event_pkg::*;
(
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en_i,
  input  logic        emit_i,
  input  event_code_e emit_code_i,
  input  logic        event_ready_i,
  output logic        event_valid_o,
  output logic [1:0]  event_code_o,
  output logic        overflow_o,
  input  logic        overflow_clr_i
);

  logic        valid_q, valid_d;
  event_code_e code_q, code_d;
  logic        ovf_q, ovf_d;
  logic        w_drop;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    w_drop  = 1'b0;

    if (emit_i) begin
      // Slot is free, or its occupant leaves this cycle: take the new event.
      if (!valid_q || event_ready_i) begin
        valid_d = 1'b1;
        code_d  = emit_code_i;
      end else begin
        w_drop = 1'b1;
      end
    end else if (valid_q && event_ready_i) begin
      valid_d = 1'b0;
    end

    // Set has priority over clear so a drop is never lost.
    if (overflow_clr_i) ovf_d = 1'b0;
    if (w_drop)         ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      valid_q <= 1'b0;
      code_q  <= EV_SINGLE;
      ovf_q   <= 1'b0;
    end else if (clk_en_i) begin
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign event_valid_o = valid_q;
  assign event_code_o  = code_q;
  assign overflow_o    = ovf_q;

endmodule : event_holding_reg
`default_nettype wire

// File: rtl/button_gesture_decoder.sv
`default_nettype none
// ============================================================================
// Module  : button_gesture_decoder
// Purpose : Classifies a stream of debounced press pulses into SINGLE,
//           DOUBLE, HOLD_START and HOLD_END events using the gap between
//           consecutive pulses. Auto-repeat pulses from a held button arrive
//           with short gaps (<= Repeat_Max_Gap_Cycles); a second press within
//           Double_Window_Cycles is a double press. Double_Window_Cycles must
//           exceed Repeat_Max_Gap_Cycles.
// Ports   : clk, async_rst_n  - clock, asynchronous active-low reset
//           clk_en            - qualifies every state/counter/handshake update
//           pulse_in          - one-cycle press pulses (repeats included)
//           event_valid       - classified event available
//           event_code        - 0 SINGLE, 1 DOUBLE, 2 HOLD_START, 3 HOLD_END
//           event_ready       - consumer accepts the event
//           overflow          - sticky: an event was dropped
//           overflow_clr      - clears overflow
// Revision: 1.0 - initial release
// ============================================================================
module button_gesture_decoder
  import button_event_pkg::*;
#(
  parameter int unsigned Repeat_Max_Gap_Cycles = 16,
  parameter int unsigned Double_Window_Cycles  = 40
) (
  input  logic       clk,
  input  logic       async_rst_n,
  input  logic       clk_en,
  input  logic       pulse_in,
  output logic       event_valid,
  output logic [1:0] event_code,
  input  logic       event_ready,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int unsigned       c_cnt_w   = $clog2(Double_Window_Cycles + 2);
  localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
  localparam logic [c_cnt_w-1:0] c_rep     = c_cnt_w'(Repeat_Max_Gap_Cycles);
  localparam logic [c_cnt_w-1:0] c_dbl     = c_cnt_w'(Double_Window_Cycles);

  gesture_state_e     state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               w_emit;
  event_code_e        w_emit_code;

  // The gap to a pulse seen now is cnt_q + 1, so "gap <= N" is "cnt_q < N".
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;
    w_emit      = 1'b0;
    w_emit_code = EV_SINGLE;

    if (pulse_in) cnt_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (pulse_in) state_d = ST_FIRST;
      end

      ST_FIRST: begin
        if (pulse_in) begin
          if (cnt_q < c_rep) begin
            state_d     = ST_HOLD;
            w_emit      = 1'b1;
            w_emit_code = EV_HOLD_START;
          end else if (cnt_q < c_dbl) begin
            state_d     = ST_IDLE;
            w_emit      = 1'b1;
            w_emit_code = EV_DOUBLE;
          end else begin
            // Window expired on this very cycle: close the first gesture as
            // SINGLE and let this pulse open a new one.
            w_emit      = 1'b1;
            w_emit_code = EV_SINGLE;
          end
        end else if (cnt_q >= c_dbl) begin
          state_d     = ST_IDLE;
          w_emit      = 1'b1;
          w_emit_code = EV_SINGLE;
        end
      end

      ST_HOLD: begin
        if (pulse_in) begin
          if (cnt_q >= c_rep) begin
            // Repeat stream ended; this pulse is a fresh press.
            state_d     = ST_FIRST;
            w_emit      = 1'b1;
            w_emit_code = EV_HOLD_END;
          end
        end else if (cnt_q >= c_rep) begin
          state_d     = ST_IDLE;
          w_emit      = 1'b1;
          w_emit_code = EV_HOLD_END;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  event_holding_reg u_event_holding_reg (
    .clk            (clk),
    .async_rst_n    (async_rst_n),
    .clk_en_i       (clk_en),
    .emit_i         (w_emit),
    .emit_code_i    (w_emit_code),
    .event_ready_i  (event_ready),
    .event_valid_o  (event_valid),
    .event_code_o   (event_code),
    .overflow_o     (overflow),
    .overflow_clr_i (overflow_clr)
  );

endmodule : button_gesture_decoder
`default_nettype wire

// File: tb/tb_button_gesture_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_gesture_decoder
// Purpose : Self-checking bench for button_gesture_decoder. Directed
//           scenarios use expected cycles derived from the gap rules; the
//           random scenario classifies a list of pulse times by their gaps
//           and replays the one-slot handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_gesture_decoder;

  localparam int R  = 16;
  localparam int D  = 40;
  localparam int RN = 3000;

  logic       clk = 1'b0;
  logic       async_rst_n;
  logic       clk_en;
  logic       pulse_in;
  logic       event_valid;
  logic [1:0] event_code;
  logic       event_ready;
  logic       overflow;
  logic       overflow_clr;

  int n_tests = 0;
  int n_fail  = 0;

  bit rp[RN];
  bit rr[RN];
  bit rc[RN];
  int me[RN];

  always #5 clk = ~clk;

  button_gesture_decoder #(
    .Repeat_Max_Gap_Cycles (R),
    .Double_Window_Cycles  (D)
  ) dut (
    .clk          (clk),
    .async_rst_n  (async_rst_n),
    .clk_en       (clk_en),
    .pulse_in     (pulse_in),
    .event_valid  (event_valid),
    .event_code   (event_code),
    .event_ready  (event_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // Leaves the bench at the start of cycle 0 (just after a falling edge);
  // the next rising edge ends cycle 0.
  task automatic apply_reset();
    pulse_in     = 1'b0;
    clk_en       = 1'b1;
    event_ready  = 1'b1;
    overflow_clr = 1'b0;
    @(negedge clk);
    async_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    async_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pulse_in = 1'b0; clk_en = 1'b1; event_ready = 1'b1; overflow_clr = 1'b0;
    async_rst_n = 1'b0;
    #2;
    n_tests++; if (event_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", event_valid); end
    n_tests++; if (event_code !== 2'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", event_code); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    // Build up a held HOLD_START plus a dropped HOLD_END, then reset async.
    apply_reset();
    event_ready = 1'b0;
    for (int t = 0; t < 45; t++) begin
      pulse_in = (t == 10 || t == 20);
      @(negedge clk);
    end
    pulse_in = 1'b0;
    n_tests++; if (event_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", event_valid); end
    n_tests++; if (event_code !== 2'd2) begin n_fail++; $display("FAIL pre_reset_code: got %0d want 2", event_code); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ovf: got %b want 1", overflow); end
    async_rst_n = 1'b0;
    #1;
    n_tests++; if (event_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", event_valid); end
    n_tests++; if (event_code !== 2'd0) begin n_fail++; $display("FAIL async_reset_code: got %0d want 0", event_code); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL async_reset_ovf: got %b want 0", overflow); end
    @(negedge clk);
    async_rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_gesture();
    apply_reset();
    for (int t = 0; t <= 120; t++) begin
      async_rst_n = !(t >= 20 && t < 23);
      #1;
      n_tests++; if (event_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid cycle %0d: got %b want 0", t, event_valid); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midreset_ovf cycle %0d: got %b want 0", t, overflow); end
      pulse_in = (t == 10);
      @(negedge clk);
    end
    pulse_in = 1'b0;
    async_rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic ev;
    apply_reset();
    for (int t = 0; t <= 70; t++) begin
      ev = (t == 52);
      n_tests++; if (event_valid !== ev) begin n_fail++; $display("FAIL single_valid cycle %0d: got %b want %b", t, event_valid, ev); end
      if (ev) begin
        n_tests++; if (event_code !== 2'd0) begin n_fail++; $display("FAIL single_code cycle %0d: got %0d want 0", t, event_code); end
      end
      pulse_in = (t == 10);
      @(negedge clk);
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_double();
    logic ev;
    apply_reset();
    for (int t = 0; t <= 100; t++) begin
      ev = (t == 41);
      n_tests++; if (event_valid !== ev) begin n_fail++; $display("FAIL double_valid cycle %0d: got %b want %b", t, event_valid, ev); end
      if (ev) begin
        n_tests++; if (event_code !== 2'd1) begin n_fail++; $display("FAIL double_code cycle %0d: got %0d want 1", t, event_code); end
      end
      pulse_in = (t == 10 || t == 40);
      @(negedge clk);
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_hold();
    logic ev;
    logic [1:0] code;
    apply_reset();
    for (int t = 0; t <= 110; t++) begin
      ev   = (t == 26 || t == 73);
      code = (t == 26) ? 2'd2 : 2'd3;
      n_tests++; if (event_valid !== ev) begin n_fail++; $display("FAIL hold_valid cycle %0d: got %b want %b", t, event_valid, ev); end
      if (ev) begin
        n_tests++; if (event_code !== code) begin n_fail++; $display("FAIL hold_code cycle %0d: got %0d want %0d", t, event_code, code); end
      end
      pulse_in = (t == 10 || t == 25 || t == 40 || t == 55);
      @(negedge clk);
    end
    pulse_in = 1'b0;
  endtask

  // Second SINGLE is dropped on cycle 141 while overflow_clr is also high
  // (set must win); a later clear takes effect one cycle after it is seen.
  task automatic test_overflow();
    logic ev, ov;
    apply_reset();
    for (int t = 0; t <= 165; t++) begin
      ev = (t >= 52 && t <= 150);
      ov = (t >= 142 && t <= 155);
      n_tests++; if (event_valid !== ev) begin n_fail++; $display("FAIL ovf_valid cycle %0d: got %b want %b", t, event_valid, ev); end
      n_tests++; if (overflow !== ov) begin n_fail++; $display("FAIL ovf_flag cycle %0d: got %b want %b", t, overflow, ov); end
      if (ev) begin
        n_tests++; if (event_code !== 2'd0) begin n_fail++; $display("FAIL ovf_code cycle %0d: got %0d want 0", t, event_code); end
      end
      pulse_in     = (t == 10 || t == 100);
      event_ready  = (t >= 150);
      overflow_clr = (t == 141 || t == 155);
      @(negedge clk);
    end
    pulse_in = 1'b0; event_ready = 1'b1; overflow_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic ev;
    logic [1:0] code;
    apply_reset();
    for (int t = 0; t <= 140; t++) begin
      ev   = (t >= 52);
      code = (t >= 131) ? 2'd1 : 2'd0;
      n_tests++; if (event_valid !== ev) begin n_fail++; $display("FAIL b2b_valid cycle %0d: got %b want %b", t, event_valid, ev); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf cycle %0d: got %b want 0", t, overflow); end
      if (ev) begin
        n_tests++; if (event_code !== code) begin n_fail++; $display("FAIL b2b_code cycle %0d: got %0d want %0d", t, event_code, code); end
      end
      pulse_in    = (t == 10 || t == 100 || t == 130);
      event_ready = (t == 130);
      @(negedge clk);
    end
    pulse_in = 1'b0; event_ready = 1'b1;
  endtask

  // Stalls delay classification by the number of disabled cycles, ignore
  // pulses, and freeze a presented event.
  task automatic test_clk_en();
    logic ev;
    apply_reset();
    for (int t = 0; t <= 90; t++) begin
      ev = (t >= 62 && t <= 65);
      n_tests++; if (event_valid !== ev) begin n_fail++; $display("FAIL clken_valid cycle %0d: got %b want %b", t, event_valid, ev); end
      if (ev) begin
        n_tests++; if (event_code !== 2'd0) begin n_fail++; $display("FAIL clken_code cycle %0d: got %0d want 0", t, event_code); end
      end
      pulse_in = (t == 10 || t == 25);
      clk_en   = !((t >= 20 && t <= 29) || (t >= 62 && t <= 64));
      @(negedge clk);
    end
    pulse_in = 1'b0; clk_en = 1'b1;
  endtask

  // Classify the pulse list by gaps; me[t] = code decided in cycle t.
  function automatic void build_model();
    int pt[$];
    int mode;   // 0 none, 1 first press pending, 2 holding
    int anchor; // time of first press (mode 1) or last repeat (mode 2)
    int q, gap;
    bit fresh;
    mode = 0; anchor = 0;
    for (int t = 0; t < RN; t++) begin
      me[t] = -1;
      if (rp[t]) pt.push_back(t);
    end
    foreach (pt[i]) begin
      q = pt[i];
      fresh = 1'b1;
      if (mode == 1) begin
        gap = q - anchor;
        if (gap <= R) begin
          me[q] = 2; mode = 2; anchor = q; fresh = 1'b0;
        end else if (gap <= D) begin
          me[q] = 1; mode = 0; fresh = 1'b0;
        end else begin
          me[anchor + D + 1] = 0; mode = 0;
        end
      end else if (mode == 2) begin
        gap = q - anchor;
        if (gap <= R) begin
          anchor = q; fresh = 1'b0;
        end else begin
          me[anchor + R + 1] = 3; mode = 0;
        end
      end
      if (fresh) begin
        mode = 1; anchor = q;
      end
    end
    if (mode == 1 && anchor + D + 1 < RN) me[anchor + D + 1] = 0;
    if (mode == 2 && anchor + R + 1 < RN) me[anchor + R + 1] = 3;
  endfunction

  task automatic test_random();
    int t, gap, k;
    logic mv, mo, set;
    logic [1:0] mc;
    for (int i = 0; i < RN; i++) begin
      rp[i] = 1'b0;
      rr[i] = ($urandom_range(0, 3) != 0);
      rc[i] = ($urandom_range(0, 29) == 0);
    end
    t = 5;
    while (t < RN - 80) begin
      rp[t] = 1'b1;
      k = $urandom_range(0, 5);
      case (k)
        0: gap = $urandom_range(1, R);
        1: gap = R + 1;
        2: gap = $urandom_range(R + 1, D);
        3: gap = D + 1;
        4: gap = D;
        default: gap = $urandom_range(D + 2, D + 60);
      endcase
      t += gap;
    end
    build_model();
    apply_reset();
    mv = 1'b0; mo = 1'b0; mc = 2'd0;
    for (int c = 0; c < RN; c++) begin
      n_tests++; if (event_valid !== mv) begin n_fail++; $display("FAIL rand_valid cycle %0d: got %b want %b", c, event_valid, mv); end
      n_tests++; if (event_code !== mc) begin n_fail++; $display("FAIL rand_code cycle %0d: got %0d want %0d", c, event_code, mc); end
      n_tests++; if (overflow !== mo) begin n_fail++; $display("FAIL rand_ovf cycle %0d: got %b want %b", c, overflow, mo); end
      pulse_in     = rp[c];
      event_ready  = rr[c];
      overflow_clr = rc[c];
      set = 1'b0;
      if (me[c] >= 0) begin
        if (!mv || rr[c]) begin mv = 1'b1; mc = me[c][1:0]; end
        else set = 1'b1;
      end else if (mv && rr[c]) begin
        mv = 1'b0;
      end
      if (set) mo = 1'b1;
      else if (rc[c]) mo = 1'b0;
      @(negedge clk);
    end
    pulse_in = 1'b0; event_ready = 1'b1; overflow_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_gesture();
    test_single();
    test_double();
    test_hold();
    test_overflow();
    test_back_to_back();
    test_clk_en();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_button_gesture_decoder
`default_nettype wire
